issue_stage: RTL and testbench

//   Decode/issue stage directly upstream of the register-file/ALU datapath. Accepts 32-bit

---
 rtl/issue_stage.sv | 143 ++++++++++++++
 tb/tb_issue_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_stage.sv
// Decode/issue stage: buffers 32-bit instruction words in a small FIFO and issues one
// decoded control bundle per cycle into a registered output stage for the datapath.
module issue_stage #(
    parameter int FIFO_DEPTH = 2,
    parameter int ZERO_R0    = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             stall,
    output logic [2:0]       op,
    output logic             form,
    output logic [1:0]       vec,
    output logic [1:0]       write,
    output logic [3:0]       Y1,
    output logic [3:0]       Y2,
    output logic [3:0]       A,
    output logic [3:0]       B,
    output logic [3:0]       C,
    output logic [3:0]       D,
    output logic [3:0]       zero_reg,
    output logic             waw_err,
    output logic [CNT_W-1:0] issued_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [FCNT_W-1:0] DEPTH_C = FCNT_W'(FIFO_DEPTH);

    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FCNT_W-1:0] fifo_cnt;
    logic [FCNT_W-1:0] fifo_cnt_next;
    logic              ready_q;
    logic              push;
    logic              pop;
    logic [31:0]       head;
    logic [1:0]        dec_write;
    logic              dec_waw;
    logic [3:0]        dec_zero;

    // Handshake: a word transfers on the rising edge where instr_valid && instr_ready.
    // instr_ready is a flop mirroring (count < FIFO_DEPTH) before any same-cycle pop,
    // so a full buffer never accepts even while it drains; it is 0 throughout reset.
    assign instr_ready = ready_q;
    assign push        = instr_valid && ready_q;
    assign pop         = !stall && (fifo_cnt != '0);
    assign head        = fifo_mem[rd_ptr];

    always_comb begin
        fifo_cnt_next = fifo_cnt;
        case ({push, pop})
            2'b10:   fifo_cnt_next = fifo_cnt + FCNT_W'(1);
            2'b01:   fifo_cnt_next = fifo_cnt - FCNT_W'(1);
            default: fifo_cnt_next = fifo_cnt;
        endcase
    end

    // Two writes to the same register in one issue: keep Y1 and flag the word.
    always_comb begin
        dec_write = head[25:24];
        dec_waw   = 1'b0;
        if ((head[25:24] == 2'b11) && (head[23:20] == head[19:16])) begin
            dec_write = 2'b01;
            dec_waw   = 1'b1;
        end
    end

    always_comb begin
        dec_zero    = 4'b0000;
        dec_zero[0] = (ZERO_R0 != 0) && (head[15:12] == 4'd0);
        dec_zero[1] = (ZERO_R0 != 0) && (head[11:8]  == 4'd0);
        dec_zero[2] = (ZERO_R0 != 0) && (head[7:4]   == 4'd0);
        dec_zero[3] = (ZERO_R0 != 0) && (head[3:0]   == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= instr;
        end
    end

    // Pointers are power-of-two wide, so they wrap modulo FIFO_DEPTH naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_cnt <= fifo_cnt_next;
            ready_q  <= (fifo_cnt_next < DEPTH_C);
        end
    end

    // Output bundle: loaded on a pop; otherwise only write drops to a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op         <= 3'b000;
            form       <= 1'b0;
            vec        <= 2'b00;
            write      <= 2'b00;
            Y1         <= 4'd0;
            Y2         <= 4'd0;
            A          <= 4'd0;
            B          <= 4'd0;
            C          <= 4'd0;
            D          <= 4'd0;
            zero_reg   <= 4'b0000;
            waw_err    <= 1'b0;
            issued_cnt <= '0;
        end else if (pop) begin
            op         <= head[31:29];
            form       <= head[28];
            vec        <= head[27:26];
            write      <= dec_write;
            Y1         <= head[23:20];
            Y2         <= head[19:16];
            A          <= head[15:12];
            B          <= head[11:8];
            C          <= head[7:4];
            D          <= head[3:0];
            zero_reg   <= dec_zero;
            issued_cnt <= issued_cnt + CNT_W'(1);
            if (dec_waw) begin
                waw_err <= 1'b1;
            end
        end else begin
            write <= 2'b00;
        end
    end

endmodule

// File: tb/tb_issue_stage.sv
// Directed bench for issue_stage: reset, decode, zero-source, backpressure, WAW, counter wrap.
module tb_issue_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;

    logic        instr_ready;
    logic [2:0]  op;
    logic        form;
    logic [1:0]  vec;
    logic [1:0]  write;
    logic [3:0]  Y1, Y2, A, B, C, D, zero_reg;
    logic        waw_err;
    logic [15:0] issued_cnt;

    logic        rdy_b, form_b, waw_b;
    logic [2:0]  op_b;
    logic [1:0]  vec_b, write_b;
    logic [3:0]  y1_b, y2_b, a_b, b_b, c_b, d_b, zero_b;
    logic [15:0] cnt_b;

    logic        rdy_c, form_c, waw_c;
    logic [2:0]  op_c;
    logic [1:0]  vec_c, write_c;
    logic [3:0]  y1_c, y2_c, a_c, b_c, c_c, d_c, zero_c;
    logic [3:0]  cnt_c;

    int checks = 0;
    int errors = 0;

    issue_stage dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .stall(stall), .op(op), .form(form), .vec(vec),
        .write(write), .Y1(Y1), .Y2(Y2), .A(A), .B(B), .C(C), .D(D),
        .zero_reg(zero_reg), .waw_err(waw_err), .issued_cnt(issued_cnt)
    );

    issue_stage #(.ZERO_R0(0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(rdy_b), .stall(stall), .op(op_b), .form(form_b), .vec(vec_b),
        .write(write_b), .Y1(y1_b), .Y2(y2_b), .A(a_b), .B(b_b), .C(c_b), .D(d_b),
        .zero_reg(zero_b), .waw_err(waw_b), .issued_cnt(cnt_b)
    );

    issue_stage #(.CNT_W(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(rdy_c), .stall(stall), .op(op_c), .form(form_c), .vec(vec_c),
        .write(write_c), .Y1(y1_c), .Y2(y2_c), .A(a_c), .B(b_c), .C(c_c), .D(d_c),
        .zero_reg(zero_c), .waw_err(waw_c), .issued_cnt(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [2:0] o, input logic f, input logic [1:0] v,
                                       input logic [1:0] w, input logic [3:0] y1, input logic [3:0] y2,
                                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                                       input logic [3:0] d);
        return {o, f, v, w, y1, y2, a, b, c, d};
    endfunction

    // Offer one word and hold it until accepted; bounded so a stuck ready cannot hang the run.
    task automatic push_one(input logic [31:0] w);
        int n;
        instr = w;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!instr_ready) begin
            errors++;
            $display("FAIL push_timeout: instr_ready got %b expected 1 within 20 cycles", instr_ready);
        end
        step();
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr_valid = 1'b0; stall = 1'b0; instr = 32'h0;
        #2;
        checks++;
        if (instr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_initial: got %b expected 0", instr_ready); end
        step(); step();
        rst_n = 1'b1;
        step(); step();
        checks++;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_release: got %b expected 1", instr_ready); end
        // Load the outputs with a nonzero word, then buffer two more under stall.
        push_one(mk(3'd6, 1'b1, 2'd3, 2'b10, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4));
        step();
        checks++;
        if (op !== 3'd6) begin errors++; $display("FAIL rst_preload_op: got %0d expected 6", op); end
        stall = 1'b1;
        push_one(mk(3'd1, 1'b0, 2'd0, 2'b01, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6));
        push_one(mk(3'd2, 1'b0, 2'd0, 2'b01, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6));
        checks++;
        if (instr_ready !== 1'b0) begin errors++; $display("FAIL rst_full_ready: got %b expected 0", instr_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({op, form, vec, write, Y1, Y2, A, B, C, D, zero_reg, waw_err} !== 39'd0) begin
            errors++;
            $display("FAIL rst_outputs: got op=%0d write=%b Y1=%0d A=%0d expected all 0", op, write, Y1, A);
        end
        checks++;
        if (issued_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", issued_cnt); end
        checks++;
        if (instr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_low: got %b expected 0", instr_ready); end
        step();
        rst_n = 1'b1;
        stall = 1'b0;
        step(); step(); step();
        checks++;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b expected 1", instr_ready); end
        checks++;
        if (write !== 2'b00 || issued_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_fifo_flushed: got write=%b cnt=%0d expected write=00 cnt=0", write, issued_cnt);
        end
    endtask

    task automatic test_single_issue();
        push_one(32'h2150_4321);
        step();
        checks++;
        if (op !== 3'd1 || form !== 1'b0 || vec !== 2'd0) begin
            errors++; $display("FAIL single_opfield: got op=%0d form=%b vec=%0d expected 1,0,0", op, form, vec);
        end
        checks++;
        if (write !== 2'b01) begin errors++; $display("FAIL single_write: got %b expected 01", write); end
        checks++;
        if (Y1 !== 4'd5 || Y2 !== 4'd0) begin errors++; $display("FAIL single_dest: got Y1=%0d Y2=%0d expected 5,0", Y1, Y2); end
        checks++;
        if ({A, B, C, D} !== 16'h4321) begin errors++; $display("FAIL single_src: got %h expected 4321", {A, B, C, D}); end
        checks++;
        if (zero_reg !== 4'b0000) begin errors++; $display("FAIL single_zero: got %b expected 0000", zero_reg); end
        checks++;
        if (issued_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d expected 1", issued_cnt); end
        step();
        checks++;
        if (write !== 2'b00) begin errors++; $display("FAIL single_bubble: got %b expected 00", write); end
        checks++;
        if (Y1 !== 4'd5 || op !== 3'd1) begin errors++; $display("FAIL single_hold: got Y1=%0d op=%0d expected 5,1", Y1, op); end
    endtask

    task automatic test_zero_source();
        push_one(32'hBA39_0608);
        step();
        checks++;
        if (zero_reg !== 4'b0101) begin errors++; $display("FAIL zero_r0_on: got %b expected 0101", zero_reg); end
        checks++;
        if (zero_b !== 4'b0000) begin errors++; $display("FAIL zero_r0_off: got %b expected 0000", zero_b); end
        checks++;
        if (op !== 3'd5 || form !== 1'b1 || vec !== 2'b10 || write !== 2'b10 || Y2 !== 4'd9) begin
            errors++;
            $display("FAIL zero_fields: got op=%0d form=%b vec=%b write=%b Y2=%0d expected 5,1,10,10,9", op, form, vec, write, Y2);
        end
        checks++;
        if (issued_cnt !== 16'd2) begin errors++; $display("FAIL zero_cnt: got %0d expected 2", issued_cnt); end
    endtask

    task automatic test_backpressure();
        logic [31:0] w0, w1, w2;
        w0 = mk(3'd3, 1'b0, 2'd1, 2'b01, 4'd10, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1);
        w1 = mk(3'd4, 1'b0, 2'd1, 2'b10, 4'd11, 4'd2, 4'd1, 4'd1, 4'd1, 4'd1);
        w2 = mk(3'd7, 1'b0, 2'd1, 2'b01, 4'd12, 4'd3, 4'd1, 4'd1, 4'd1, 4'd1);
        stall = 1'b1;
        instr_valid = 1'b1;
        instr = w0; step();
        instr = w1; step();
        checks++;
        if (instr_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got ready=%b expected 0", instr_ready); end
        instr = w2; step();
        checks++;
        if (instr_ready !== 1'b0 || write !== 2'b00) begin
            errors++; $display("FAIL bp_hold: got ready=%b write=%b expected 0,00", instr_ready, write);
        end
        stall = 1'b0;
        step();
        checks++;
        if (Y1 !== 4'd10 || write !== 2'b01 || op !== 3'd3) begin
            errors++; $display("FAIL bp_first: got Y1=%0d write=%b op=%0d expected 10,01,3", Y1, write, op);
        end
        step();
        instr_valid = 1'b0;
        checks++;
        if (Y1 !== 4'd11 || write !== 2'b10) begin errors++; $display("FAIL bp_second: got Y1=%0d write=%b expected 11,10", Y1, write); end
        step();
        checks++;
        if (Y1 !== 4'd12 || write !== 2'b01 || op !== 3'd7) begin
            errors++; $display("FAIL bp_third: got Y1=%0d write=%b op=%0d expected 12,01,7", Y1, write, op);
        end
        checks++;
        if (issued_cnt !== 16'd5) begin errors++; $display("FAIL bp_cnt: got %0d expected 5", issued_cnt); end
        step();
        checks++;
        if (write !== 2'b00) begin errors++; $display("FAIL bp_drain: got %b expected 00", write); end
    endtask

    task automatic test_waw();
        checks++;
        if (waw_err !== 1'b0) begin errors++; $display("FAIL waw_initial: got %b expected 0", waw_err); end
        push_one(32'h4377_1234);
        step();
        checks++;
        if (write !== 2'b01 || waw_err !== 1'b1) begin
            errors++; $display("FAIL waw_hit: got write=%b waw=%b expected 01,1", write, waw_err);
        end
        push_one(32'h4312_0000);
        step();
        checks++;
        if (write !== 2'b11 || waw_err !== 1'b1) begin
            errors++; $display("FAIL waw_sticky: got write=%b waw=%b expected 11,1", write, waw_err);
        end
        checks++;
        if (zero_reg !== 4'b1111 || issued_cnt !== 16'd7) begin
            errors++; $display("FAIL waw_clean: got zero=%b cnt=%0d expected 1111,7", zero_reg, issued_cnt);
        end
    endtask

    task automatic test_back_to_back_wrap();
        logic [3:0] k4;
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        stall = 1'b0;
        step(); step();
        checks++;
        if (waw_err !== 1'b0 || cnt_c !== 4'd0) begin
            errors++; $display("FAIL wrap_reset: got waw=%b cnt=%0d expected 0,0", waw_err, cnt_c);
        end
        instr_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            k4 = 4'(k);
            instr = mk(3'd1, 1'b0, 2'd0, 2'b01, k4, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1);
            step();
            if (k >= 1) begin
                checks++;
                if (Y1 !== 4'(k - 1) || write !== 2'b01 || issued_cnt !== 16'(k)) begin
                    errors++;
                    $display("FAIL wrap_b2b_%0d: got Y1=%0d write=%b cnt=%0d expected %0d,01,%0d", k, Y1, write, issued_cnt, k - 1, k);
                end
            end
        end
        instr_valid = 1'b0;
        step();
        checks++;
        if (Y1 !== 4'd0 || write !== 2'b01 || issued_cnt !== 16'd17) begin
            errors++; $display("FAIL wrap_last: got Y1=%0d write=%b cnt=%0d expected 0,01,17", Y1, write, issued_cnt);
        end
        checks++;
        if (cnt_c !== 4'd1) begin errors++; $display("FAIL wrap_cnt4: got %0d expected 1", cnt_c); end
        step();
        checks++;
        if (write !== 2'b00 || write_c !== 2'b00) begin
            errors++; $display("FAIL wrap_drain: got write=%b write4=%b expected 00,00", write, write_c);
        end
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_zero_source();
        test_backpressure();
        test_waw();
        test_back_to_back_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
